// File: rtl/fxp_add_arbiter_pkg.sv
// Shared constants for the fixed-point adder arbiter: FSM encodings and
// saturation bounds for an arbitrary operand width.
package fxp_add_arbiter_pkg;

    localparam logic [0:0] FXP_ARB_EMPTY = 1'b0;
    localparam logic [0:0] FXP_ARB_FULL  = 1'b1;

    // Callers truncate the 64-bit value to their own width.
    function automatic logic [63:0] fxp_sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fxp_sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fxp_add_arbiter_if.sv
// Requester/consumer bus for the shared adder; operands are packed per requester.
interface fxp_add_arbiter_if #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_a;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_b;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [BIT_WIDTH-1:0]         resp_y;
    logic [ID_WIDTH-1:0]          resp_id;
    logic                         resp_ovf;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_id, resp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_y, resp_id, resp_ovf
    );
endinterface

// File: rtl/fxp_add_arbiter_add.sv
// Wrap-around two's-complement adder shared by all requesters.
module fxp_add #(
    parameter int BIT_WIDTH = 16
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic [BIT_WIDTH-1:0] y
);
    assign y = a + b;
endmodule

// File: rtl/fxp_add_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module fxp_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_id
);
    logic [ID_WIDTH:0]   w_sum;
    logic [ID_WIDTH-1:0] w_idx;
    logic                w_found;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, ptr} + (ID_WIDTH+1)'(i);
            if (w_sum >= (ID_WIDTH+1)'(NUM_REQ))
                w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
            w_idx = w_sum[ID_WIDTH-1:0];
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
                w_found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fxp_add_arbiter.sv
// Shares one fxp_add among NUM_REQ requesters; registers sum, id and overflow
// and holds them until the consumer accepts.
module fxp_add_arbiter
    import fxp_add_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int SATURATE  = 0
) (
    input logic               CLK,
    input logic               nRST,
    fxp_add_arbiter_if.slave  bus
);
    localparam int MSB = BIT_WIDTH - 1;
    localparam logic [BIT_WIDTH-1:0] SAT_MAX = BIT_WIDTH'(fxp_sat_max(BIT_WIDTH));
    localparam logic [BIT_WIDTH-1:0] SAT_MIN = BIT_WIDTH'(fxp_sat_min(BIT_WIDTH));

    logic [0:0]           r_state;
    logic [ID_WIDTH-1:0]  r_rr_ptr;
    logic [BIT_WIDTH-1:0] r_y;
    logic [ID_WIDTH-1:0]  r_id;
    logic                 r_ovf;

    logic                 w_can_issue;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_WIDTH-1:0]  w_gnt_id;
    logic                 w_grant;
    logic [ID_WIDTH-1:0]  w_ptr_nxt;
    logic [BIT_WIDTH-1:0] w_a;
    logic [BIT_WIDTH-1:0] w_b;
    logic [BIT_WIDTH-1:0] w_sum;
    logic                 w_ovf;
    logic [BIT_WIDTH-1:0] w_y;

    // Gating with nRST drops any grant in a reset cycle and keeps req_ready low.
    assign w_can_issue = (r_state == FXP_ARB_EMPTY) || bus.resp_ready;

    fxp_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req    (bus.req_valid),
        .ptr    (r_rr_ptr),
        .en     (w_can_issue && nRST),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign bus.req_ready = w_gnt;
    assign w_grant       = |w_gnt;
    assign w_ptr_nxt     = (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    assign w_a = bus.req_a[int'(w_gnt_id)*BIT_WIDTH +: BIT_WIDTH];
    assign w_b = bus.req_b[int'(w_gnt_id)*BIT_WIDTH +: BIT_WIDTH];

    fxp_add #(.BIT_WIDTH(BIT_WIDTH)) u_add (
        .a (w_a),
        .b (w_b),
        .y (w_sum)
    );

    // Overflow only when operand signs agree and the result sign differs.
    assign w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
    assign w_y   = (SATURATE != 0 && w_ovf) ? (w_a[MSB] ? SAT_MIN : SAT_MAX) : w_sum;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= FXP_ARB_EMPTY;
            r_rr_ptr <= '0;
            r_y      <= '0;
            r_id     <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_y      <= w_y;
                r_id     <= w_gnt_id;
                r_ovf    <= w_ovf;
                r_rr_ptr <= w_ptr_nxt;
                r_state  <= FXP_ARB_FULL;
            end else if (r_state == FXP_ARB_FULL && bus.resp_ready) begin
                r_state  <= FXP_ARB_EMPTY;
            end
        end
    end

    assign bus.resp_valid = (r_state == FXP_ARB_FULL);
    assign bus.resp_y     = r_y;
    assign bus.resp_id    = r_id;
    assign bus.resp_ovf   = r_ovf;
endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Directed bench for fxp_add_arbiter: a wrap and a saturating instance see the
// same stimulus; a round-robin model feeds a scoreboard queue.
module tb_fxp_add_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  vld;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic        rdy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] yw;
        logic [15:0] ys;
        logic [1:0]  id;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    bit   m_full = 1'b0;
    int   m_ptr  = 0;

    always #5 clk = ~clk;

    fxp_add_arbiter_if #(.BIT_WIDTH(16), .NUM_REQ(4), .ID_WIDTH(2)) if0 ();
    fxp_add_arbiter_if #(.BIT_WIDTH(16), .NUM_REQ(4), .ID_WIDTH(2)) if1 ();

    assign if0.req_valid  = vld;
    assign if0.req_a      = a_bus;
    assign if0.req_b      = b_bus;
    assign if0.resp_ready = rdy;
    assign if1.req_valid  = vld;
    assign if1.req_a      = a_bus;
    assign if1.req_b      = b_bus;
    assign if1.resp_ready = rdy;

    fxp_add_arbiter #(.BIT_WIDTH(16), .NUM_REQ(4), .ID_WIDTH(2), .SATURATE(0)) u_dut0 (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (if0)
    );

    fxp_add_arbiter #(.BIT_WIDTH(16), .NUM_REQ(4), .ID_WIDTH(2), .SATURATE(1)) u_dut1 (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (if1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        a_bus[i*16 +: 16] = a;
        b_bus[i*16 +: 16] = b;
    endtask

    // Called just after a falling edge with inputs settled; returns after the next falling edge.
    task automatic cycle();
        int          g;
        int          k;
        logic [3:0]  oh;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
        #2;
        g = -1;
        if (nrst && (!m_full || rdy))
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (g < 0 && vld[k]) g = k;
            end
        oh = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_ready_wrap", 32'(if0.req_ready), 32'(oh));
        chk("req_ready_sat",  32'(if1.req_ready), 32'(oh));
        chk("resp_valid_wrap", 32'(if0.resp_valid), 32'(m_full));
        chk("resp_valid_sat",  32'(if1.resp_valid), 32'(m_full));
        if (m_full && q.size() > 0) begin
            chk("resp_y_wrap",   32'(if0.resp_y),   32'(q[0].yw));
            chk("resp_y_sat",    32'(if1.resp_y),   32'(q[0].ys));
            chk("resp_id",       32'(if0.resp_id),  32'(q[0].id));
            chk("resp_id_sat",   32'(if1.resp_id),  32'(q[0].id));
            chk("resp_ovf_wrap", 32'(if0.resp_ovf), 32'(q[0].ovf));
            chk("resp_ovf_sat",  32'(if1.resp_ovf), 32'(q[0].ovf));
        end
        @(posedge clk);
        if (!nrst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            q.delete();
        end else begin
            if (m_full && rdy) void'(q.pop_front());
            if (g >= 0) begin
                a     = a_bus[g*16 +: 16];
                b     = b_bus[g*16 +: 16];
                e.yw  = a + b;
                e.ovf = (a[15] == b[15]) && (e.yw[15] != a[15]);
                e.ys  = e.ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : e.yw;
                e.id  = 2'(g);
                q.push_back(e);
                m_ptr = (g + 1) % 4;
            end
            m_full = (g >= 0) || (m_full && !rdy);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_resp_y",   32'(if0.resp_y),   32'h0);
        chk("rst_resp_id",  32'(if0.resp_id),  32'h0);
        chk("rst_resp_ovf", 32'(if0.resp_ovf), 32'h0);
        chk("rst_resp_y_sat", 32'(if1.resp_y), 32'h0);
    endtask

    initial begin
        nrst  = 1'b0;
        vld   = 4'b0000;
        rdy   = 1'b0;
        a_bus = '0;
        b_bus = '0;
        @(negedge clk);
        cycle();
        vld = 4'b1111;
        cycle();
        chk_reset_outputs();

        // Single request on requester 2.
        nrst = 1'b1;
        vld  = 4'b0100;
        rdy  = 1'b1;
        set_op(2, 16'h0003, 16'h0004);
        cycle();
        vld = 4'b0000;
        cycle();

        // Fairness: everyone valid, consumer always ready.
        for (int i = 0; i < 4; i++) set_op(i, 16'(i*16'h0100 + 1), 16'(i*16'h0010));
        vld = 4'b1111;
        for (int n = 0; n < 9; n++) cycle();
        vld = 4'b0000;
        cycle();

        // Backpressure on requester 1, operands change during the hold.
        vld = 4'b0010;
        set_op(1, 16'h1234, 16'h0101);
        cycle();
        rdy = 1'b0;
        set_op(1, 16'h5555, 16'h0001);
        for (int n = 0; n < 5; n++) cycle();
        rdy = 1'b1;
        cycle();
        vld = 4'b0000;
        cycle();

        // Overflow in both directions, then negative operands without overflow.
        vld = 4'b0001;
        set_op(0, 16'h7FFF, 16'h0001); cycle();
        set_op(0, 16'h8000, 16'hFFFF); cycle();
        set_op(0, 16'h8000, 16'h8000); cycle();
        set_op(0, 16'hFFFE, 16'hFFFD); cycle();
        vld = 4'b0000;
        cycle();

        // Mid-operation reset with a held result.
        vld = 4'b1000;
        rdy = 1'b0;
        set_op(3, 16'h0100, 16'h0200);
        cycle();
        cycle();
        nrst = 1'b0;
        vld  = 4'b1010;
        cycle();
        chk_reset_outputs();
        nrst = 1'b1;
        rdy  = 1'b1;
        set_op(1, 16'h0011, 16'h0022);
        cycle();
        vld = 4'b0000;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
